// File: rtl/multdiv_issue_ctrl_pkg.sv
// Processor constants shared by the multdiv issue controller and its helpers.
package multdiv_issue_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0]  RSTATUS_REG   = 5'd30;
    localparam logic [DATA_W-1:0] MULT_EXC_CODE = 32'd4;
    localparam logic [DATA_W-1:0] DIV_EXC_CODE  = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    function automatic logic [DATA_W-1:0] exc_code(input logic is_mult);
        exc_code = is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Counts BUSY cycles of a multdiv operation; tc flags the cycle on whose
// closing edge the TIMEOUT_CYCLES-th BUSY cycle ends.
module md_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: clear wins over increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = en & (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues MULT/DIV from the DX latch to multdiv, stalls until the result is
// ready and presents a one-cycle writeback (redirected to rstatus on exception).
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dx_valid,
    input  logic              dx_is_mult,
    input  logic              dx_is_div,
    input  logic [DATA_W-1:0] dx_operandA,
    input  logic [DATA_W-1:0] dx_operandB,
    input  logic [REG_W-1:0]  dx_rd,
    output logic              md_ctrl_MULT,
    output logic              md_ctrl_DIV,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              stall,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    md_state_e         state_q, state_d;
    logic              op_mult_q, op_mult_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              ctrl_mult_q, ctrl_mult_d;
    logic              ctrl_div_q, ctrl_div_d;
    logic              wb_we_q, wb_we_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic accept_s;
    logic finish_s;
    logic exc_s;
    logic cnt_clr_s;
    logic cnt_en_s;
    logic timeout_s;

    // Both op bits set is an illegal encoding and is simply not accepted.
    assign accept_s = (state_q == ST_IDLE) & dx_valid & (dx_is_mult ^ dx_is_div);
    assign finish_s = (state_q == ST_BUSY) & (md_resultRDY | timeout_s);
    assign exc_s    = md_resultRDY ? md_exception : 1'b1;

    md_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (timeout_s)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY:  state_d = finish_s ? ST_DONE : ST_BUSY;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // state-decoded outputs; stall is released in DONE so DX moves on
    always_comb begin
        stall     = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE:  stall = accept_s;
            ST_ISSUE: begin
                stall     = 1'b1;
                cnt_clr_s = 1'b1;
            end
            ST_BUSY:  begin
                stall    = 1'b1;
                cnt_en_s = 1'b1;
            end
            ST_DONE:  stall = 1'b0;
            default:  stall = 1'b0;
        endcase
    end

    // operand/op latches and the start pulse, which lands in ISSUE
    always_comb begin
        op_mult_d   = op_mult_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ctrl_mult_d = accept_s & dx_is_mult;
        ctrl_div_d  = accept_s & dx_is_div;
        if (accept_s) begin
            op_mult_d = dx_is_mult;
            rd_d      = dx_rd;
            opa_d     = dx_operandA;
            opb_d     = dx_operandB;
        end else begin
            op_mult_d = op_mult_q;
        end
    end

    // writeback packet, loaded on the edge into DONE and zero elsewhere
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = '0;
        wb_data_d = '0;
        if (finish_s) begin
            if (exc_s) begin
                wb_we_d   = 1'b1;
                wb_rd_d   = RSTATUS_REG;
                wb_data_d = exc_code(op_mult_q);
            end else begin
                wb_we_d   = (rd_q != 5'd0);
                wb_rd_d   = rd_q;
                wb_data_d = md_result;
            end
        end else begin
            wb_we_d = 1'b0;
        end
    end

    // datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            op_mult_q   <= 1'b0;
            rd_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            op_mult_q   <= op_mult_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign md_ctrl_MULT = ctrl_mult_q;
    assign md_ctrl_DIV  = ctrl_div_q;
    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; the bench plays the multdiv unit.
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        dx_valid, dx_is_mult, dx_is_div;
    logic [31:0] dx_operandA, dx_operandB;
    logic [4:0]  dx_rd;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_operandA, md_operandB;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests  = 0;
    int failed = 0;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_valid     (dx_valid),
        .dx_is_mult   (dx_is_mult),
        .dx_is_div    (dx_is_div),
        .dx_operandA  (dx_operandA),
        .dx_operandB  (dx_operandB),
        .dx_rd        (dx_rd),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic dx_idle();
        dx_valid    = 1'b0;
        dx_is_mult  = 1'b0;
        dx_is_div   = 1'b0;
        dx_operandA = 32'd0;
        dx_operandB = 32'd0;
        dx_rd       = 5'd0;
    endtask

    // Drive one op from an IDLE cycle through DONE. n = BUSY cycles until
    // ready (0: multdiv never answers, expect timeout after 64 BUSY cycles).
    task automatic run_op(input string nm, input logic is_mult, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int n,
                          input logic [31:0] res, input logic exc, input logic exp_we,
                          input logic [4:0] exp_rd, input logic [31:0] exp_data,
                          input logic chk_data);
        int nb;
        int stall_cnt;
        nb          = (n == 0) ? 64 : n;
        stall_cnt   = 0;
        dx_valid    = 1'b1;
        dx_is_mult  = is_mult;
        dx_is_div   = ~is_mult;
        dx_operandA = a;
        dx_operandB = b;
        dx_rd       = rd;
        #1;
        chk({nm, " accept stall"}, {31'd0, stall}, 32'd1);
        chk({nm, " accept ctrl"}, {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        if (stall) stall_cnt++;
        cyc();
        chk({nm, " issue ctrl"}, {30'd0, md_ctrl_MULT, md_ctrl_DIV}, {30'd0, is_mult, ~is_mult});
        chk({nm, " issue opA"}, md_operandA, a);
        chk({nm, " issue opB"}, md_operandB, b);
        if (stall) stall_cnt++;
        for (int k = 1; k <= nb; k++) begin
            cyc();
            if (n != 0 && k == n) begin
                md_resultRDY = 1'b1;
                md_result    = res;
                md_exception = exc;
            end
            #1;
            if (md_ctrl_MULT || md_ctrl_DIV) chk({nm, " busy ctrl"}, {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
            if (!stall) chk({nm, " busy stall"}, {31'd0, stall}, 32'd1);
            if (stall) stall_cnt++;
        end
        chk({nm, " busy opA"}, md_operandA, a);
        chk({nm, " busy opB"}, md_operandB, b);
        cyc();
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
        #1;
        chk({nm, " stall count"}, stall_cnt, 2 + nb);
        chk({nm, " done stall"}, {31'd0, stall}, 32'd0);
        chk({nm, " done ctrl"}, {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk({nm, " done we"}, {31'd0, wb_we}, {31'd0, exp_we});
        if (chk_data) begin
            chk({nm, " done rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
            chk({nm, " done data"}, wb_data, exp_data);
        end
    endtask

    initial begin
        reset        = 1'b1;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        dx_idle();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("reset wb", {5'd0, wb_we, wb_rd, wb_data[20:0]}, 32'd0);
        chk("reset opA", md_operandA, 32'd0);
        chk("reset opB", md_operandB, 32'd0);

        // MULT 3x7 -> r5, ready in the 32nd BUSY cycle (stall 34 cycles)
        cyc();
        run_op("mul3x7", 1'b1, 32'd3, 32'd7, 5'd5, 32, 32'd21, 1'b0, 1'b1, 5'd5, 32'd21, 1'b1);
        // DX holds the completed op during DONE; pipeline advances at that edge
        cyc();
        dx_idle();
        #1;
        chk("post done stall", {31'd0, stall}, 32'd0);
        chk("post done we", {31'd0, wb_we}, 32'd0);
        cyc();
        chk("post done no pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);

        // DIV 10/0 -> divide-by-zero exception
        run_op("div10by0", 1'b0, 32'd10, 32'd0, 5'd7, 5, 32'd0, 1'b1, 1'b1, 5'd30, 32'd5, 1'b1);
        cyc();
        dx_idle();

        // MULT overflow
        run_op("mulovf", 1'b1, 32'h7FFF_FFFF, 32'd2, 5'd3, 32, 32'hFFFF_FFFE, 1'b1, 1'b1, 5'd30, 32'd4, 1'b1);
        cyc();
        dx_idle();

        // DIV 100/7 to r0, then DIV 9/3 accepted in the very next IDLE cycle
        run_op("div100by7", 1'b0, 32'd100, 32'd7, 5'd0, 8, 32'd14, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc();
        run_op("div9by3", 1'b0, 32'd9, 32'd3, 5'd2, 3, 32'd3, 1'b0, 1'b1, 5'd2, 32'd3, 1'b1);
        cyc();
        dx_idle();

        // ready coincides with timeout: ready wins
        run_op("rdy_at_tc", 1'b1, 32'd5, 32'd17, 5'd4, 64, 32'd85, 1'b0, 1'b1, 5'd4, 32'd85, 1'b1);
        cyc();
        dx_idle();

        // multdiv never answers: forced exception after 64 BUSY cycles
        run_op("timeout", 1'b1, 32'd6, 32'd6, 5'd9, 0, 32'd0, 1'b0, 1'b1, 5'd30, 32'd4, 1'b1);
        cyc();
        dx_idle();

        // reset mid-BUSY, then a stale ready
        dx_valid    = 1'b1;
        dx_is_div   = 1'b1;
        dx_operandA = 32'd50;
        dx_operandB = 32'd5;
        dx_rd       = 5'd8;
        cyc();
        cyc();
        cyc();
        #1;
        chk("pre-reset busy stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        dx_idle();
        md_resultRDY = 1'b1;
        md_result    = 32'd10;
        #1;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("rst we", {31'd0, wb_we}, 32'd0);
        chk("rst opA", md_operandA, 32'd0);
        cyc();
        md_resultRDY = 1'b0;
        md_result    = 32'd0;
        #1;
        chk("stale rdy we", {31'd0, wb_we}, 32'd0);
        chk("stale rdy stall", {31'd0, stall}, 32'd0);

        // illegal encoding: both op bits set
        dx_valid    = 1'b1;
        dx_is_mult  = 1'b1;
        dx_is_div   = 1'b1;
        dx_operandA = 32'd1;
        dx_operandB = 32'd1;
        dx_rd       = 5'd1;
        #1;
        chk("illegal stall", {31'd0, stall}, 32'd0);
        cyc();
        chk("illegal ctrl", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        chk("illegal stall2", {31'd0, stall}, 32'd0);
        chk("illegal opA", md_operandA, 32'd0);
        cyc();
        chk("illegal ctrl2", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        dx_idle();
        // still in IDLE: a legal op is accepted immediately
        run_op("after_illegal", 1'b0, 32'd9, 32'd2, 5'd6, 2, 32'd4, 1'b0, 1'b1, 5'd6, 32'd4, 1'b1);
        cyc();
        dx_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
